// File: rtl/mtimer_multi.sv
// Multi-hart machine timer: shared 64-bit mtime, per-hart mtimecmp and msip.
// Decodes a 64 KiB window at BASE; read data is registered (one-cycle latency).
module mtimer_multi #(
    parameter int unsigned NUM_HARTS = 1,
    parameter logic [31:0] BASE      = 32'h4400_0000,
    parameter int unsigned DIV       = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 valid,
    input  logic                 write,
    input  logic [3:0]           wmask,
    input  logic [31:0]          wdata,
    input  logic [31:0]          addr,
    output logic [31:0]          rdata,
    output logic [NUM_HARTS-1:0] irq_timer,
    output logic [NUM_HARTS-1:0] irq_soft
);

    localparam logic [15:0] DivLast = 16'(DIV - 1);

    logic        hit;
    logic [15:0] off;
    logic [13:0] word;
    logic        wr_en;
    logic        sel_msip;
    logic        sel_cmp;
    logic        sel_mtime_lo;
    logic        sel_mtime_hi;
    logic [2:0]  msip_idx;
    logic [2:0]  cmp_idx;
    logic        unused_bits;

    logic [63:0]                 mtime_q, mtime_d;
    logic [15:0]                 presc_q, presc_d;
    logic [NUM_HARTS-1:0][63:0]  cmp_q, cmp_d;
    logic [NUM_HARTS-1:0]        msip_q, msip_d;
    logic [NUM_HARTS-1:0]        irq_timer_q, irq_timer_d;
    logic [31:0]                 rdata_q, rdata_d;

    assign hit          = addr[31:16] == BASE[31:16];
    assign off          = addr[15:0];
    assign word         = off[15:2];
    assign wr_en        = valid & write & hit;
    assign msip_idx     = off[4:2];
    assign cmp_idx      = off[5:3];
    assign sel_msip     = {18'b0, word} < NUM_HARTS;
    assign sel_cmp      = (off[15:14] == 2'b01) && ({21'b0, off[13:3]} < NUM_HARTS);
    assign sel_mtime_lo = word == 14'h2FFE;
    assign sel_mtime_hi = word == 14'h2FFF;
    assign unused_bits  = ^off[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        mtime_d = mtime_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        msip_d  = msip_q;

        if (presc_q == DivLast) begin
            presc_d = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            presc_d = presc_q + 16'd1;
        end

        // An mtime write replaces the increment entirely and restarts the prescaler.
        if (wr_en && sel_mtime_lo) begin
            mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata, wmask)};
            presc_d = '0;
        end
        if (wr_en && sel_mtime_hi) begin
            mtime_d = {merge(mtime_q[63:32], wdata, wmask), mtime_q[31:0]};
            presc_d = '0;
        end

        for (int h = 0; h < NUM_HARTS; h++) begin
            if (wr_en && sel_cmp && cmp_idx == 3'(h)) begin
                if (off[2]) cmp_d[h][63:32] = merge(cmp_q[h][63:32], wdata, wmask);
                else        cmp_d[h][31:0]  = merge(cmp_q[h][31:0], wdata, wmask);
            end
            if (wr_en && sel_msip && msip_idx == 3'(h) && wmask[0]) begin
                msip_d[h] = wdata[0];
            end
        end
    end

    always_comb begin
        irq_timer_d = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            irq_timer_d[h] = mtime_q >= cmp_q[h];
        end
    end

    always_comb begin
        rdata_d = 32'hFFFF_FFFF;
        if (hit) begin
            rdata_d = '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (sel_msip && msip_idx == 3'(h)) rdata_d = {31'b0, msip_q[h]};
                if (sel_cmp && cmp_idx == 3'(h)) begin
                    rdata_d = off[2] ? cmp_q[h][63:32] : cmp_q[h][31:0];
                end
            end
            if (sel_mtime_lo) rdata_d = mtime_q[31:0];
            if (sel_mtime_hi) rdata_d = mtime_q[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mtime_q     <= '0;
            presc_q     <= '0;
            cmp_q       <= '1;
            msip_q      <= '0;
            irq_timer_q <= '0;
            rdata_q     <= '0;
        end else begin
            mtime_q     <= mtime_d;
            presc_q     <= presc_d;
            cmp_q       <= cmp_d;
            msip_q      <= msip_d;
            irq_timer_q <= irq_timer_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign irq_timer = irq_timer_q;
    assign irq_soft  = msip_q;

endmodule

// File: tb/tb_mtimer_multi.sv
// Bench for mtimer_multi: two instances on one bus (4 harts/DIV=1 and 1 hart/DIV=4),
// read results checked through a scoreboard one cycle after issue.
module tb_mtimer_multi;

    localparam logic [31:0] BASE = 32'h4400_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] rdata_a, rdata_b;
    logic [3:0]  irq_timer_a, irq_soft_a;
    logic [0:0]  irq_timer_b, irq_soft_b;

    mtimer_multi #(.NUM_HARTS(4), .BASE(BASE), .DIV(1)) u_a (
        .clk       (clk),
        .rstn      (rstn),
        .valid     (valid),
        .write     (write),
        .wmask     (wmask),
        .wdata     (wdata),
        .addr      (addr),
        .rdata     (rdata_a),
        .irq_timer (irq_timer_a),
        .irq_soft  (irq_soft_a)
    );

    mtimer_multi #(.NUM_HARTS(1), .BASE(BASE), .DIV(4)) u_b (
        .clk       (clk),
        .rstn      (rstn),
        .valid     (valid),
        .write     (write),
        .wmask     (wmask),
        .wdata     (wdata),
        .addr      (addr),
        .rdata     (rdata_b),
        .irq_timer (irq_timer_b),
        .irq_soft  (irq_soft_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, "/a"}, rdata_a, e.exp_a);
            chk({e.name, "/b"}, rdata_b, e.exp_b);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        valid = v;
        write = w;
        addr  = a;
        wdata = d;
        wmask = m;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] ea, input logic [31:0] eb);
        sb.push_back('{name: name, exp_a: ea, exp_b: eb});
    endtask

    initial begin
        vecs[0] = '{BASE + 32'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[1] = '{BASE + 32'h4004, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{BASE + 32'h0000, 32'h0,         32'h0};
        vecs[3] = '{BASE + 32'h0014, 32'h0,         32'h0};
        vecs[4] = '{BASE + 32'hBFFC, 32'h0,         32'h0};
        vecs[5] = '{32'h7000_0010,   32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[6] = '{BASE + 32'h0100, 32'h0,         32'h0};
        vecs[7] = '{BASE + 32'h4018, 32'hFFFF_FFFF, 32'h0};

        // Reset with an out-of-window address: rdata must still read 0.
        rstn = 1'b0;
        drive(1'b0, 1'b0, 32'h7000_0010, 32'h0, 4'h0);
        repeat (3) tick();
        chk("rst_rdata/a", rdata_a, 32'h0);
        chk("rst_rdata/b", rdata_b, 32'h0);
        chk("rst_irq_timer/a", {28'b0, irq_timer_a}, 32'h0);
        chk("rst_irq_soft/a", {28'b0, irq_soft_a}, 32'h0);

        // Free-running count after release: DIV=1 steps every cycle, DIV=4 every fourth.
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, BASE + 32'hBFF8, 32'h0, 4'h0);
            expect_rd($sformatf("mtime_lo_k%0d", k), 32'(k), 32'(k / 4));
            tick();
        end

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, vecs[i].addr, 32'h0, 4'h0);
            expect_rd($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b);
            tick();
        end

        // Byte-masked write; the same-cycle read sees the old value.
        drive(1'b1, 1'b1, BASE + 32'h4000, 32'h0000_AB00, 4'b0010);
        expect_rd("cmp0_lo_same_cycle", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b0, BASE + 32'h4000, 32'h0, 4'h0);
        expect_rd("cmp0_lo_masked", 32'hFFFF_ABFF, 32'hFFFF_ABFF);
        tick();

        // Software interrupts.
        drive(1'b1, 1'b1, BASE + 32'h0008, 32'hFFFF_FFFF, 4'hF);
        expect_rd("msip2_pre", 32'h0, 32'h0);
        tick();
        chk("irq_soft_msip2/a", {28'b0, irq_soft_a}, 32'h4);
        chk("irq_soft_msip2/b", {31'b0, irq_soft_b}, 32'h0);
        drive(1'b1, 1'b0, BASE + 32'h0008, 32'h0, 4'h0);
        expect_rd("msip2_read", 32'h1, 32'h0);
        tick();
        drive(1'b1, 1'b1, BASE + 32'h0014, 32'hFFFF_FFFF, 4'hF);
        expect_rd("msip5_wr", 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b0, BASE + 32'h0014, 32'h0, 4'h0);
        expect_rd("msip5_read", 32'h0, 32'h0);
        tick();
        chk("irq_soft_after_msip5/a", {28'b0, irq_soft_a}, 32'h4);

        // Reset overrides a simultaneous mtime write.
        rstn = 1'b0;
        drive(1'b1, 1'b1, BASE + 32'hBFF8, 32'h0000_1234, 4'hF);
        tick();
        chk("rst2_rdata/a", rdata_a, 32'h0);
        chk("rst2_rdata/b", rdata_b, 32'h0);
        chk("rst2_irq_soft/a", {28'b0, irq_soft_a}, 32'h0);
        chk("rst2_irq_timer/a", {28'b0, irq_timer_a}, 32'h0);

        // Timer interrupt at mtime == 20 (edge numbers counted from release).
        rstn = 1'b1;
        drive(1'b1, 1'b1, BASE + 32'h4000, 32'd20, 4'hF);
        expect_rd("rst2_cmp0_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b1, BASE + 32'h4004, 32'h0, 4'hF);
        expect_rd("rst2_cmp0_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b0, BASE + 32'hBFF8, 32'h0, 4'h0);
        expect_rd("rst2_mtime_lo", 32'd2, 32'd0);
        tick();
        drive(1'b0, 1'b0, BASE + 32'hBFF8, 32'h0, 4'h0);
        repeat (17) tick();
        chk("irq_before_20/a", {28'b0, irq_timer_a}, 32'h0);
        tick();
        chk("irq_at_20/a", {28'b0, irq_timer_a}, 32'h1);
        chk("irq_at_20/b", {31'b0, irq_timer_b}, 32'h0);
        drive(1'b1, 1'b1, BASE + 32'h4004, 32'h1, 4'hF);
        tick();
        chk("irq_hold/a", {28'b0, irq_timer_a}, 32'h1);

        // mtime low = 100 mid-count; DIV=4 next steps 4 cycles after the write.
        drive(1'b1, 1'b1, BASE + 32'hBFF8, 32'd100, 4'hF);
        expect_rd("mtime_pre_wr", 32'd22, 32'd5);
        tick();
        chk("irq_clear/a", {28'b0, irq_timer_a}, 32'h0);
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, BASE + 32'hBFF8, 32'h0, 4'h0);
            expect_rd($sformatf("mtime_after_wr_j%0d", j), 32'(100 + j), (j < 4) ? 32'd100 : 32'd101);
            tick();
        end

        // 64-bit wrap: every hart with all-ones compare pulses for one cycle.
        drive(1'b1, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        tick();
        chk("wrap_irq_e1/a", {28'b0, irq_timer_a}, 32'h0);
        drive(1'b1, 1'b1, BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        tick();
        chk("wrap_irq_e2/a", {28'b0, irq_timer_a}, 32'h0);
        drive(1'b1, 1'b0, BASE + 32'hBFFC, 32'h0, 4'h0);
        expect_rd("wrap_hi_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk("wrap_irq_e3/a", {28'b0, irq_timer_a}, 32'hF);
        chk("wrap_irq_e3/b", {31'b0, irq_timer_b}, 32'h1);
        drive(1'b1, 1'b0, BASE + 32'hBFF8, 32'h0, 4'h0);
        expect_rd("wrap_lo_zero", 32'h0, 32'hFFFF_FFFF);
        tick();
        chk("wrap_irq_e4/a", {28'b0, irq_timer_a}, 32'h0);
        drive(1'b1, 1'b0, BASE + 32'hBFFC, 32'h0, 4'h0);
        expect_rd("wrap_hi_zero", 32'h0, 32'hFFFF_FFFF);
        tick();

        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
